// File: rtl/motor_ctrl_pkg.sv
// Shared types and constants for the crash-avoidance drive-train controller.
// State encodings are visible on state_o, so they are fixed here.
package motor_ctrl_pkg;

    localparam int   PWM_W   = 8;
    localparam logic DIR_FWD = 1'b1;
    localparam logic DIR_REV = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRIVE   = 3'd1,
        ST_BRAKE   = 3'd2,
        ST_REVERSE = 3'd3,
        ST_TURN    = 3'd4
    } state_e;

endpackage

// File: rtl/crash_debounce.sv
// Two-flop synchronizer for the asynchronous crash flag followed by a
// stable-run debouncer; crash_db_o only moves after a full stable run.
module crash_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic crash_db_o
);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_q, db_d;

    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        if (sync_q[1] != db_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                db_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            cnt_q  <= '0;
            db_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], async_i};
            cnt_q  <= cnt_d;
            db_q   <= db_d;
        end
    end

    assign crash_db_o = db_q;

endmodule

// File: rtl/crash_avoid_motor_ctrl.sv
// Avoidance sequencer: brake, reverse, pivot right, then resume driving.
// Outputs are decoded from the next state so dir and PWM move with state_o.
module crash_avoid_motor_ctrl
    import motor_ctrl_pkg::*;
#(
    parameter int               DEBOUNCE_CYCLES = 1000,
    parameter int               BRAKE_CYCLES    = 5000000,
    parameter int               REVERSE_CYCLES  = 20000000,
    parameter int               TURN_CYCLES     = 15000000,
    parameter logic [PWM_W-1:0] REVERSE_DUTY    = 8'd128,
    parameter int               CNT_W           = 25
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             is_crash,
    input  logic [PWM_W-1:0] speed_duty,
    output logic             pwm_l,
    output logic             pwm_r,
    output logic             dir_l,
    output logic             dir_r,
    output logic             brake,
    output logic [2:0]       state_o,
    output logic [7:0]       crash_count
);

    localparam logic [CNT_W-1:0] BRAKE_LD = CNT_W'(BRAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] REV_LD   = CNT_W'(REVERSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TURN_LD  = CNT_W'(TURN_CYCLES - 1);

    logic             crash_db;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [PWM_W-1:0] pwm_cnt_q;
    logic [7:0]       count_q, count_d;
    logic [PWM_W-1:0] duty_d;
    logic             dir_l_d, dir_r_d, brake_d;
    logic             pwm_q, dir_l_q, dir_r_q, brake_q;

    crash_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_db (
        .clk       (clk),
        .reset     (reset),
        .async_i   (is_crash),
        .crash_db_o(crash_db)
    );

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        count_d = count_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!crash_db) state_d = ST_DRIVE;
                end
                ST_DRIVE: begin
                    if (crash_db) begin
                        state_d = ST_BRAKE;
                        phase_d = BRAKE_LD;
                        count_d = count_q + {7'd0, count_q != 8'hFF};
                    end
                end
                ST_BRAKE: begin
                    phase_d = phase_q - CNT_W'(1);
                    if (phase_q == '0) begin
                        state_d = ST_REVERSE;
                        phase_d = REV_LD;
                    end
                end
                ST_REVERSE: begin
                    phase_d = phase_q - CNT_W'(1);
                    if (phase_q == '0) begin
                        state_d = ST_TURN;
                        phase_d = TURN_LD;
                    end
                end
                ST_TURN: begin
                    phase_d = phase_q - CNT_W'(1);
                    if (phase_q == '0) begin
                        state_d = crash_db ? ST_BRAKE : ST_DRIVE;
                        phase_d = BRAKE_LD;
                        if (crash_db) begin
                            count_d = count_q + {7'd0, count_q != 8'hFF};
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        duty_d  = '0;
        dir_l_d = DIR_FWD;
        dir_r_d = DIR_FWD;
        brake_d = 1'b0;
        unique case (state_d)
            ST_DRIVE:   duty_d = speed_duty;
            ST_BRAKE:   brake_d = 1'b1;
            ST_REVERSE: begin
                duty_d  = REVERSE_DUTY;
                dir_l_d = DIR_REV;
                dir_r_d = DIR_REV;
            end
            ST_TURN: begin
                duty_d  = REVERSE_DUTY;
                dir_r_d = DIR_REV;
            end
            default: duty_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            phase_q   <= '0;
            pwm_cnt_q <= '0;
            count_q   <= '0;
            pwm_q     <= 1'b0;
            dir_l_q   <= DIR_FWD;
            dir_r_q   <= DIR_FWD;
            brake_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            pwm_cnt_q <= pwm_cnt_q + PWM_W'(1);
            count_q   <= count_d;
            pwm_q     <= pwm_cnt_q < duty_d;
            dir_l_q   <= dir_l_d;
            dir_r_q   <= dir_r_d;
            brake_q   <= brake_d;
        end
    end

    assign pwm_l       = pwm_q;
    assign pwm_r       = pwm_q;
    assign dir_l       = dir_l_q;
    assign dir_r       = dir_r_q;
    assign brake       = brake_q;
    assign state_o     = state_q;
    assign crash_count = count_q;

endmodule
